// File: rtl/i2c_adc_target.sv
// rtl/i2c_adc_target.sv - I2C target emulating a 16-bit ADC register map
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   scl_pin           I2C clock input (never stretched)
//   sda_pin           I2C data, open-drain (driven 0 or released)
//   conv_data/valid   local conversion result, loaded into register 0
//   config_out        register 1
//   lo_thresh_out     register 2
//   hi_thresh_out     register 3
//   wr_strobe/wr_ptr  pulse and register index on each committed 16-bit write
//   rd_strobe         pulse after the LSB of a register-0 read is shifted out
//   busy              address-matched START seen, no STOP yet
//
// Optional build macro: I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority
// filter on SCL and SDA after the synchronisers.

module i2c_adc_target #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h48,
    parameter logic [15:0] CONFIG_RST = 16'h8583
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_pin,
    inout  wire         sda_pin,
    input  logic [15:0] conv_data,
    input  logic        conv_valid,
    output logic [15:0] config_out,
    output logic [15:0] lo_thresh_out,
    output logic [15:0] hi_thresh_out,
    output logic        wr_strobe,
    output logic [1:0]  wr_ptr,
    output logic        rd_strobe,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE,
        S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
    } state_t;

    // Synchronisers reset to the idle-bus level so reset release is not
    // mistaken for a bus edge that matters.
    logic [1:0] r_scl_sync, r_sda_sync;
    logic       w_scl, w_sda;
    logic       r_scl_prev, r_sda_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_pin};
            r_sda_sync <= {r_sda_sync[0], sda_pin};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] r_scl_hist, r_sda_hist;
    logic       r_scl_filt, r_sda_filt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_hist <= 3'b111;
            r_sda_hist <= 3'b111;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[1:0], r_scl_sync[1]};
            r_sda_hist <= {r_sda_hist[1:0], r_sda_sync[1]};
            r_scl_filt <= (r_scl_hist[0] & r_scl_hist[1]) | (r_scl_hist[0] & r_scl_hist[2]) |
                          (r_scl_hist[1] & r_scl_hist[2]);
            r_sda_filt <= (r_sda_hist[0] & r_sda_hist[1]) | (r_sda_hist[0] & r_sda_hist[2]) |
                          (r_sda_hist[1] & r_sda_hist[2]);
        end
    end

    assign w_scl = r_scl_filt;
    assign w_sda = r_sda_filt;
`else
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    // SDA edges only count as START/STOP while SCL was and still is high.
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

    state_t      r_state;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_hold_msb;
    logic [7:0]  r_tx;
    logic [15:0] r_snap;
    logic [15:0] r_reg0, r_config, r_lo, r_hi;
    logic [1:0]  r_ptr, r_wr_ptr;
    logic        r_ack_on, r_rw, r_first_byte, r_have_msb, r_rd_lsb;
    logic        r_sda_oe, r_wr_strobe, r_rd_strobe, r_busy;

    logic [15:0] w_reg_sel;
    logic [7:0]  w_next_byte;

    always_comb begin
        w_reg_sel = r_hi;
        case (r_ptr)
            2'd0:    w_reg_sel = r_reg0;
            2'd1:    w_reg_sel = r_config;
            2'd2:    w_reg_sel = r_lo;
            default: w_reg_sel = r_hi;
        endcase
    end

    // After an LSB the read wraps back to the MSB of the same snapshot.
    assign w_next_byte = r_rd_lsb ? r_snap[15:8] : r_snap[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'd0;
            r_hold_msb   <= 8'd0;
            r_tx         <= 8'd0;
            r_snap       <= 16'd0;
            r_reg0       <= 16'd0;
            r_config     <= CONFIG_RST;
            r_lo         <= 16'h8000;
            r_hi         <= 16'h7FFF;
            r_ptr        <= 2'd0;
            r_wr_ptr     <= 2'd0;
            r_ack_on     <= 1'b0;
            r_rw         <= 1'b0;
            r_first_byte <= 1'b1;
            r_have_msb   <= 1'b0;
            r_rd_lsb     <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_wr_strobe  <= 1'b0;
            r_rd_strobe  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_wr_strobe <= 1'b0;
            r_rd_strobe <= 1'b0;
            if (conv_valid)
                r_reg0 <= conv_data;

            if (w_stop) begin
                r_state    <= S_IDLE;
                r_sda_oe   <= 1'b0;
                r_busy     <= 1'b0;
                r_ack_on   <= 1'b0;
                r_have_msb <= 1'b0;
            end else if (w_start) begin
                r_state      <= S_ADDR;
                r_sda_oe     <= 1'b0;
                r_bit_cnt    <= 4'd0;
                r_ack_on     <= 1'b0;
                r_have_msb   <= 1'b0;
                r_first_byte <= 1'b1;
            end else begin
                case (r_state)
                    S_ADDR, S_WR_BYTE: begin
                        if (w_scl_rise) begin
                            r_shift <= {r_shift[6:0], w_sda};
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= 4'd0;
                                r_state   <= (r_state == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end

                    // r_ack_on separates the fall that starts the ACK from the
                    // fall that ends it.
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_on) begin
                                if (r_shift[7:1] == SLAVE_ADDR) begin
                                    r_sda_oe <= 1'b1;
                                    r_ack_on <= 1'b1;
                                    r_busy   <= 1'b1;
                                    r_rw     <= r_shift[0];
                                    if (r_shift[0])
                                        r_snap <= w_reg_sel;
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end else begin
                                r_ack_on  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                if (r_rw) begin
                                    r_state  <= S_RD_BYTE;
                                    r_tx     <= r_snap[15:8];
                                    r_sda_oe <= ~r_snap[15];
                                    r_rd_lsb <= 1'b0;
                                end else begin
                                    r_state      <= S_WR_BYTE;
                                    r_sda_oe     <= 1'b0;
                                    r_first_byte <= 1'b1;
                                end
                            end
                        end
                    end

                    S_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_on) begin
                                r_sda_oe <= 1'b1;
                                r_ack_on <= 1'b1;
                                if (r_first_byte) begin
                                    r_ptr        <= r_shift[1:0];
                                    r_first_byte <= 1'b0;
                                end else if (!r_have_msb) begin
                                    r_hold_msb <= r_shift;
                                    r_have_msb <= 1'b1;
                                end else begin
                                    r_have_msb <= 1'b0;
                                    // Register 0 is read-only from the bus.
                                    if (r_ptr != 2'd0) begin
                                        case (r_ptr)
                                            2'd1:    r_config <= {r_hold_msb, r_shift};
                                            2'd2:    r_lo     <= {r_hold_msb, r_shift};
                                            default: r_hi     <= {r_hold_msb, r_shift};
                                        endcase
                                        r_wr_strobe <= 1'b1;
                                        r_wr_ptr    <= r_ptr;
                                    end
                                end
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_ack_on <= 1'b0;
                                r_state  <= S_WR_BYTE;
                            end
                        end
                    end

                    // Bit 7 is already on the line when this state is entered;
                    // each fall moves the next bit out until 8 rises are seen.
                    S_RD_BYTE: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_RD_ACK;
                                if (r_rd_lsb && r_ptr == 2'd0)
                                    r_rd_strobe <= 1'b1;
                            end else begin
                                r_sda_oe <= ~r_tx[6];
                                r_tx     <= {r_tx[6:0], 1'b0};
                            end
                        end
                    end

                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda)
                                r_state <= S_IGNORE;
                            else
                                r_ack_on <= 1'b1;
                        end else if (w_scl_fall && r_ack_on) begin
                            r_ack_on  <= 1'b0;
                            r_bit_cnt <= 4'd0;
                            r_state   <= S_RD_BYTE;
                            r_tx      <= w_next_byte;
                            r_sda_oe  <= ~w_next_byte[7];
                            r_rd_lsb  <= ~r_rd_lsb;
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

    assign sda_pin       = r_sda_oe ? 1'b0 : 1'bz;
    assign config_out    = r_config;
    assign lo_thresh_out = r_lo;
    assign hi_thresh_out = r_hi;
    assign wr_strobe     = r_wr_strobe;
    assign wr_ptr        = r_wr_ptr;
    assign rd_strobe     = r_rd_strobe;
    assign busy          = r_busy;

endmodule

// File: tb/tb_i2c_adc_target.sv
// tb/tb_i2c_adc_target.sv - directed self-checking bench for i2c_adc_target

module tb_i2c_adc_target;

    localparam int H = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scl = 1'b1;
    logic        m_sda_low = 1'b0;
    logic [15:0] conv_data = 16'd0;
    logic        conv_valid = 1'b0;
    logic [15:0] config_out, lo_thresh_out, hi_thresh_out;
    logic        wr_strobe, rd_strobe, busy;
    logic [1:0]  wr_ptr;
    wire         sda_bus;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_adc_target dut (
        .clk           (clk),
        .reset         (reset),
        .scl_pin       (scl),
        .sda_pin       (sda_bus),
        .conv_data     (conv_data),
        .conv_valid    (conv_valid),
        .config_out    (config_out),
        .lo_thresh_out (lo_thresh_out),
        .hi_thresh_out (hi_thresh_out),
        .wr_strobe     (wr_strobe),
        .wr_ptr        (wr_ptr),
        .rd_strobe     (rd_strobe),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    int n_rd    = 0;
    int n_tlow  = 0;

    always @(negedge clk) begin
        if (wr_strobe) n_wr++;
        if (rd_strobe) n_rd++;
        if (!m_sda_low && sda_bus === 1'b0) n_tlow++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        wait_clk(H);
        scl = 1'b1;
        wait_clk(H);
        m_sda_low = 1'b1;
        wait_clk(H);
        scl = 1'b0;
        wait_clk(4);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        wait_clk(H);
        scl = 1'b1;
        wait_clk(H);
        m_sda_low = 1'b0;
        wait_clk(H);
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b;
        wait_clk(H);
        scl = 1'b1;
        wait_clk(H);
        scl = 1'b0;
        wait_clk(4);
    endtask

    task automatic recv_bit(output logic b);
        m_sda_low = 1'b0;
        wait_clk(H);
        scl = 1'b1;
        wait_clk(H / 2);
        b = sda_bus;
        wait_clk(H / 2);
        scl = 1'b0;
        wait_clk(4);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
        acked = (a === 1'b0);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~master_ack);
    endtask

    logic       a0, a1, a2, a3;
    logic [7:0] d0, d1, d2;
    int         wr_base, rd_base;

    initial begin
        wait_clk(5);
        check("rst_sda", {15'd0, sda_bus}, 16'h0001);
        check("rst_config", config_out, 16'h8583);
        check("rst_lo", lo_thresh_out, 16'h8000);
        check("rst_hi", hi_thresh_out, 16'h7FFF);
        check("rst_flags", {12'd0, wr_ptr, wr_strobe, rd_strobe}, 16'h0000);
        check("rst_busy", {15'd0, busy}, 16'h0000);
        reset = 1'b0;
        wait_clk(5);

        // Wrong address 0x49: nothing on the bus from the target.
        wr_base = n_wr; rd_base = n_rd; n_tlow = 0;
        i2c_start();
        write_byte(8'h92, a0);
        check("bad_busy", {15'd0, busy}, 16'h0000);
        write_byte(8'h01, a1);
        write_byte(8'h12, a2);
        write_byte(8'h34, a3);
        i2c_stop();
        check("bad_acks", {12'd0, a0, a1, a2, a3}, 16'h0000);
        check("bad_sda_low", n_tlow[15:0], 16'd0);
        check("bad_config", config_out, 16'h8583);
        check("bad_strobes", 16'(n_wr - wr_base + n_rd - rd_base), 16'd0);

        // Config write.
        wr_base = n_wr;
        i2c_start();
        write_byte(8'h90, a0);
        check("cfg_busy", {15'd0, busy}, 16'h0001);
        write_byte(8'h01, a1);
        write_byte(8'h42, a2);
        write_byte(8'h43, a3);
        i2c_stop();
        check("cfg_acks", {12'd0, a0, a1, a2, a3}, 16'h000F);
        check("cfg_value", config_out, 16'h4243);
        check("cfg_wr_cnt", 16'(n_wr - wr_base), 16'd1);
        check("cfg_wr_ptr", {14'd0, wr_ptr}, 16'h0001);
        check("cfg_busy_after", {15'd0, busy}, 16'h0000);

        // Conversion result read back over I2C.
        @(negedge clk);
        conv_data = 16'hABCD; conv_valid = 1'b1;
        @(negedge clk);
        conv_valid = 1'b0; conv_data = 16'h0000;
        rd_base = n_rd;
        i2c_start();
        write_byte(8'h90, a0);
        write_byte(8'h00, a1);
        i2c_stop();
        i2c_start();
        write_byte(8'h91, a2);
        read_byte(1'b1, d0);
        read_byte(1'b0, d1);
        check("rd0_acks", {13'd0, a0, a1, a2}, 16'h0007);
        check("rd0_msb", {8'd0, d0}, 16'h00AB);
        check("rd0_lsb", {8'd0, d1}, 16'h00CD);
        check("rd0_sda_released", {15'd0, sda_bus}, 16'h0001);
        i2c_stop();
        check("rd0_strobe_cnt", 16'(n_rd - rd_base), 16'd1);

        // Writes to register 0 are acknowledged and dropped.
        wr_base = n_wr;
        i2c_start();
        write_byte(8'h90, a0);
        write_byte(8'h00, a1);
        write_byte(8'h12, a2);
        write_byte(8'h34, a3);
        i2c_stop();
        check("r0w_acks", {12'd0, a0, a1, a2, a3}, 16'h000F);
        check("r0w_wr_cnt", 16'(n_wr - wr_base), 16'd0);
        i2c_start();
        write_byte(8'h91, a0);
        read_byte(1'b1, d0);
        read_byte(1'b0, d1);
        i2c_stop();
        check("r0w_readback", {d0, d1}, 16'hABCD);

        // Pointer 3 via repeated START, MSB/LSB/MSB wrap.
        i2c_start();
        write_byte(8'h90, a0);
        write_byte(8'h03, a1);
        i2c_start();
        write_byte(8'h91, a2);
        read_byte(1'b1, d0);
        read_byte(1'b1, d1);
        read_byte(1'b0, d2);
        check("hi_busy", {15'd0, busy}, 16'h0001);
        i2c_stop();
        check("hi_acks", {13'd0, a0, a1, a2}, 16'h0007);
        check("hi_bytes", {8'd0, d0}, 16'h007F);
        check("hi_byte1", {8'd0, d1}, 16'h00FF);
        check("hi_byte2", {8'd0, d2}, 16'h007F);

        // Reset in the middle of a read MSB.
        i2c_start();
        write_byte(8'h90, a0);
        write_byte(8'h01, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        i2c_stop();
        check("pre_rst_config", config_out, 16'h1122);
        i2c_start();
        write_byte(8'h91, a0);
        wait_clk(2);
        check("mid_read_drive", {15'd0, sda_bus}, 16'h0000);
        reset = 1'b1;
        #1;
        check("async_release", {15'd0, sda_bus}, 16'h0001);
        check("rst_config2", config_out, 16'h8583);
        wait_clk(3);
        reset = 1'b0;
        wait_clk(3);
        i2c_stop();
        wr_base = n_wr;
        i2c_start();
        write_byte(8'h90, a0);
        write_byte(8'h02, a1);
        write_byte(8'h55, a2);
        write_byte(8'hAA, a3);
        i2c_stop();
        check("post_rst_acks", {12'd0, a0, a1, a2, a3}, 16'h000F);
        check("post_rst_lo", lo_thresh_out, 16'h55AA);
        check("post_rst_wr", {12'(n_wr - wr_base), wr_ptr, 2'b00}, 16'h0018);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/i2c_adc_target.md
# i2c_adc_target

I2C target (slave) that emulates the register interface of the 16-bit ADC on our sensor bus at 7-bit address 0x48. It responds to the same transaction sequences our `i2c_master` issues: pointer write, 16-bit register write, and 16-bit register read. It is used as an in-fabric loopback and bench partner for the master, and as a bridge that exposes locally produced conversion results over I2C.

## Interface
- `SLAVE_ADDR`, default 7'h48: the 7-bit address this target responds to.
- `CONFIG_RST`, default 16'h8583: reset value of the config register.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `scl_pin` in 1: I2C clock. Input only; this block never stretches the clock.
- `sda_pin` inout 1: I2C data, open-drain. The block drives 0 when `sda_oe`=1 and high-Z otherwise.
- `conv_data` in 16: new conversion result.
- `conv_valid` in 1: when high, `conv_data` is loaded into register 0.
- `config_out` out 16: register 1.
- `lo_thresh_out` out 16: register 2.
- `hi_thresh_out` out 16: register 3.
- `wr_strobe` out 1: one-cycle pulse when a 16-bit register write commits.
- `wr_ptr` out 2: register index of the last committed write.
- `rd_strobe` out 1: one-cycle pulse when the LSB of register 0 has been shifted out.
- `busy` out 1: high from an address-matched START until the next STOP.

## Operation
- **Input synchronisation:** SCL and SDA pass through 2-flop synchronisers. SCL rise and fall are edge-detected on the synchronised signals.
- **START:** SDA falls while SCL is high. This includes a repeated START, which aborts the current transfer from any state and goes to ADDR.
- **STOP:** SDA rises while SCL is high. From any state it goes to IDLE, releases SDA, clears `busy` and discards any partially received data.
- **State machine:**
  - **IDLE**
  - **ADDR:** 8 bits are sampled on SCL rise, MSB first, with R/W last.
  - **ADDR_ACK:** On a match, SDA is driven low from the SCL fall after bit 8 until the next SCL fall. On a mismatch, the block goes to IGNORE, which waits for START or STOP.
  - **WR_BYTE / WR_ACK:**
    - The first byte is the pointer. Bits [1:0] are used and bits [7:2] are ignored.
    - Following bytes alternate MSB, then LSB, into a 16-bit holding register.
    - On the LSB ACK, the target register at the pointer is written, `wr_strobe` pulses and `wr_ptr` = pointer.
    - Writes to register 0 are ACKed but discarded, with no strobe.
    - The pointer does not auto-increment. A third data byte starts a new MSB/LSB pair to the same register.
    - Every write byte is ACKed.
  - **RD_BYTE / RD_ACK:**
    - On the address-ACK SCL fall, register[pointer] is snapshotted.
    - The block sends the MSB, then the LSB, then repeats the MSB, and so on.
    - Each bit is placed on SDA after an SCL fall. A 0 bit sets `sda_oe`=1; a 1 bit releases SDA.
    - SDA is released during the master ACK bit, and the ACK is sampled on SCL rise.
    - NACK leads to IGNORE. ACK leads to the next byte.
    - `rd_strobe` pulses after the LSB of a pointer-0 read.
- **Register 0 loading:** `conv_valid` loads register 0 every cycle it is high. An in-flight read is unaffected because it uses the snapshot.

## Timing
- Reset values:
  - `sda_oe`=0 (SDA released), state IDLE.
  - Pointer 0.
  - Reg0 = 0, config = `CONFIG_RST`, lo = 16'h8000, hi = 16'h7FFF.
  - `wr_ptr`=0, `wr_strobe`=`rd_strobe`=`busy`=0.
- Reset asserted mid-transaction releases SDA asynchronously. The block only resumes decoding on the next START after reset deasserts.
- Detection latency from a pin edge to the internal edge is 2 clk.
- `sda_oe` updates 1 clk after a detected SCL fall. This gives 3 clk from the pin edge, and under 1 µs at 100 MHz.
- Minimum SCL high and low time is 6 clk (8 clk with the filter).
- `wr_strobe` asserts 1 clk after the SCL fall that starts the LSB ACK. The register outputs update in the same cycle.
- A `conv_valid` on the same cycle as a snapshot: the snapshot captures the old value.

## Configuration
- **`I2C_TARGET_GLITCH_FILTER_EN`** defined: SCL and SDA each pass through a 3-sample majority filter after the synchronisers.
  - Pulses of 1 clk or shorter are rejected.
  - Detection latency rises to 4 clk.
  - Minimum SCL high/low becomes 8 clk.
- Undefined: no filter, 2 clk latency.

## Test plan
- START, 0x90, 0x01, 0x42, 0x43, STOP -> 4 ACKs, `config_out`=16'h4243, one `wr_strobe` with `wr_ptr`=1, `busy` low after STOP.
- `conv_valid` pulse with `conv_data`=16'hABCD; then START 0x90 0x00 STOP; START 0x91, read, ACK, read, NACK, STOP -> bytes 0xAB, 0xCD, one `rd_strobe`, SDA released after NACK.
- START 0x92, 0x01, 0x12, 0x34, STOP -> no ACK at any bit (SDA high), `config_out` stays 16'h8583, no strobes.
- START 0x90, 0x00, 0x12, 0x34, STOP -> all ACKed, register 0 unchanged, no `wr_strobe`.
- START 0x90, 0x03, repeated START, 0x91, read 3 bytes with ACK, ACK, NACK -> 0x7F, 0xFF, 0x7F.
- Write 0x90 0x01 0x11 0x22, then assert `reset` mid-way through a read MSB -> `sda_oe`=0 immediately, `config_out`=16'h8583, next transaction decodes normally.
